// File: rtl/dual_port_sram_ctrl.sv
// Single-clock true-dual-port RAM with two Avalon-MM slaves, a readdatavalid
// pipeline and a zero-fill clear engine that owns port A while it runs.

module dpsc_lane #(
    parameter int BYTE_SIZE  = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [BYTE_SIZE-1:0]  wd_a,
    input  logic                  re_a,
    output logic [BYTE_SIZE-1:0]  q_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [BYTE_SIZE-1:0]  wd_b,
    input  logic                  re_b,
    output logic [BYTE_SIZE-1:0]  q_b
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [BYTE_SIZE-1:0] mem [DEPTH];

    // Port A is applied last so it owns this lane on a same-address collision.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= wd_b;
        if (we_a) mem[addr_a] <= wd_a;
    end

    // Reads sample the pre-write contents, giving old data on read-during-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q_a <= '0;
        else if (re_a) q_a <= mem[addr_a];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q_b <= '0;
        else if (re_b) q_b <= mem[addr_b];
    end
endmodule

module dpsc_rdpipe #(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc,
    input  logic [DATA_WIDTH-1:0] q1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);
    logic [READ_LATENCY:1] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc;
            for (int s = 2; s <= READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    assign rvalid = vld_pipe[READ_LATENCY];

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] q2;
            // Second stage loads only on a valid beat so readdata holds otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)           q2 <= '0;
                else if (vld_pipe[1]) q2 <= q1;
            end
            assign rdata = q2;
        end else begin : g_lat1
            assign rdata = q1;
        end
    endgenerate
endmodule

module dual_port_sram_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int BYTE_SIZE      = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  byteenable,
    input  logic                             chipselect,
    input  logic                             read,
    input  logic                             write,
    input  logic [DATA_WIDTH-1:0]            writedata,
    output logic [DATA_WIDTH-1:0]            readdata,
    output logic                             readdatavalid,
    output logic                             waitrequest,
    input  logic [ADDR_WIDTH-1:0]            address2,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  byteenable2,
    input  logic                             chipselect2,
    input  logic                             read2,
    input  logic                             write2,
    input  logic [DATA_WIDTH-1:0]            writedata2,
    output logic [DATA_WIDTH-1:0]            readdata2,
    output logic                             readdatavalid2,
    output logic                             waitrequest2,
    input  logic                             clear_req,
    output logic                             clear_busy
);
    localparam int NB = DATA_WIDTH / BYTE_SIZE;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  busy;

    assign busy         = (state == CLEAR);
    assign clear_busy   = busy;
    assign waitrequest  = busy;
    assign waitrequest2 = busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (clear_req) state <= CLEAR;
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (&clr_cnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A write strobe suppresses a simultaneous read on the same port.
    logic acc_wr_a, acc_rd_a, acc_wr_b, acc_rd_b;
    assign acc_wr_a = chipselect  & write  & ~busy;
    assign acc_rd_a = chipselect  & read   & ~write  & ~busy;
    assign acc_wr_b = chipselect2 & write2 & ~busy;
    assign acc_rd_b = chipselect2 & read2  & ~write2 & ~busy;

    logic [NB-1:0]                we_a, we_b;
    logic [ADDR_WIDTH-1:0]        addr_a;
    logic [NB-1:0][BYTE_SIZE-1:0] wd_a, wd_b, q1_a, q1_b;

    // The clear engine borrows port A; no host access can be accepted meanwhile.
    assign addr_a = busy ? clr_cnt : address;
    assign wd_a   = busy ? '0 : writedata;
    assign we_a   = busy ? '1 : ({NB{acc_wr_a}} & byteenable);
    assign wd_b   = writedata2;
    assign we_b   = {NB{acc_wr_b}} & byteenable2;

    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane
            dpsc_lane #(
                .BYTE_SIZE  (BYTE_SIZE),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_lane (
                .clk    (clk),
                .rst_n  (reset_n),
                .we_a   (we_a[i]),
                .addr_a (addr_a),
                .wd_a   (wd_a[i]),
                .re_a   (acc_rd_a),
                .q_a    (q1_a[i]),
                .we_b   (we_b[i]),
                .addr_b (address2),
                .wd_b   (wd_b[i]),
                .re_b   (acc_rd_b),
                .q_b    (q1_b[i])
            );
        end
    endgenerate

    dpsc_rdpipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_a (
        .clk    (clk),
        .rst_n  (reset_n),
        .acc    (acc_rd_a),
        .q1     (q1_a),
        .rdata  (readdata),
        .rvalid (readdatavalid)
    );

    dpsc_rdpipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_b (
        .clk    (clk),
        .rst_n  (reset_n),
        .acc    (acc_rd_b),
        .q1     (q1_b),
        .rdata  (readdata2),
        .rvalid (readdatavalid2)
    );
endmodule

// File: doc/dual_port_sram_ctrl.md
Name: dual_port_sram_ctrl

Overview:
- Parametrised single-clock true-dual-port on-chip RAM with two Avalon-MM slave ports, s1 (A) and s2 (B).
- Next generation of the fixed 16-bit x 4096 dual-port SRAM blocks in the Computer_System.
- Adds configurable width, depth and read latency, a readdatavalid pipeline, deterministic write-collision and read-during-write rules, and a hardware clear engine that zero-fills the array after reset or on request.
- NPU datapath masters sit on port B; the HPS bridge sits on port A.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_SIZE.
ADDR_WIDTH, 12, word address width; depth = 2**ADDR_WIDTH.
BYTE_SIZE, 8, bits per byte lane; lanes NB = DATA_WIDTH/BYTE_SIZE.
READ_LATENCY, 1, read latency in cycles from accepted read to readdatavalid; legal values are 1 or 2.
CLEAR_ON_RESET, 1, 1 = run the clear engine after reset release; 0 = array content is undefined after reset.

Ports:
clk  in  1  single clock for both ports and the clear engine.
reset_n  in  1  asynchronous, active-low reset.
address  in  ADDR_WIDTH  port A word address.
byteenable  in  NB  port A byte lanes.
chipselect  in  1  port A select.
read  in  1  port A read strobe.
write  in  1  port A write strobe.
writedata  in  DATA_WIDTH  port A write data.
readdata  out  DATA_WIDTH  port A read data.
readdatavalid  out  1  port A read data valid.
waitrequest  out  1  port A stall.
address2, byteenable2, chipselect2, read2, write2, writedata2  in  as port A  port B equivalents.
readdata2, readdatavalid2, waitrequest2  out  as port A  port B equivalents.
clear_req  in  1  one-cycle pulse that starts a zero-fill.
clear_busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (reset_n low, asynchronous):
  - readdata, readdata2, readdatavalid, readdatavalid2 = 0.
  - Internal latency pipeline flushed.
  - Clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - clear_busy and waitrequest* take their values from that state.
  - The array itself is not touched asynchronously.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req=1.
  - In CLEAR: write all-zero to word[cnt] with all lanes enabled, one word per cycle; cnt increments each cycle.
  - CLEAR -> IDLE in the cycle after cnt = 2**ADDR_WIDTH-1 is written; cnt wraps to 0.
  - A full clear takes exactly 2**ADDR_WIDTH cycles.
  - clear_req while in CLEAR is ignored (no restart).
  - reset_n low during CLEAR aborts the clear; it restarts from address 0 after release if CLEAR_ON_RESET=1.
- Wait states:
  - waitrequest = waitrequest2 = clear_busy = (state==CLEAR).
  - No accesses are accepted in CLEAR; masters hold their requests.
  - In IDLE, waitrequest is 0; every access completes with zero wait states.
- Access acceptance:
  - A port accepts an access when chipselect & (read|write) & ~waitrequest.
  - If read and write are both high, only the write is performed.
- Writes:
  - Byte-lane masked: lane i is updated only if byteenable[i]=1.
  - byteenable=0 writes nothing.
- Reads:
  - Address sampled at acceptance.
  - READ_LATENCY=1: readdata and readdatavalid are registered at the next clock edge.
  - READ_LATENCY=2: one extra output register stage.
  - readdatavalid is a one-cycle pulse per accepted read.
  - Back-to-back reads are fully pipelined, one per cycle.
  - readdata holds its last value when readdatavalid=0.
- Same-cycle write collision (both ports write the same address):
  - Per lane: port A wins where byteenable[i]=1; port B's lane is written where A's byteenable[i]=0 and B's byteenable2[i]=1.
  - Writes to different addresses proceed independently.
- Mixed-port read-during-write: a port reading the address the other port writes in the same cycle returns OLD data.
- A read issued the cycle after a write (either port) returns the new data.
- Array is a behavioural reg array inferable as M10K. A merged collision path is acceptable in RTL.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> clear_busy=1 and waitrequest=1 for exactly 16 cycles after reset_n rises; then all 16 words read back 0x0000.
- Port A write 0xBEEF to address 5, byteenable=2'b11; port B reads address 5 the next cycle -> readdata2=0xBEEF with readdatavalid2 one cycle after acceptance (READ_LATENCY=1), or two cycles after (READ_LATENCY=2).
- Same-cycle collision at address 7: A writes 0x1122 with be=2'b10, B writes 0x3344 with be=2'b11 -> word[7]=0x1144.
- Word 9 = 0x0000; in the same cycle A writes 0xAAAA to 9 and B reads 9 -> readdata2=0x0000; B reading 9 on the next cycle -> 0xAAAA.
- Four back-to-back reads on port A of addresses 0..3 preloaded with 0x10..0x13 -> readdatavalid high for 4 consecutive cycles with data 0x10, 0x11, 0x12, 0x13 in order.
- clear_req pulse, then reset_n pulsed low at clear cycle 6, then a second clear_req mid-clear -> clear restarts from 0 after reset, the second pulse is ignored, and total busy after release is 16 cycles.
